// File: rtl/cpu_out_uart_tx_if.sv
// Output-trace bus between the CPU output byte and the UART logger.
// master = CPU/top side, slave = the logger itself.
interface cpu_out_uart_tx_if;
    logic [7:0] out_byte;
    logic       en;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;

    modport master (
        output out_byte, en,
        input  tx, busy, fifo_count, overflow
    );

    modport slave (
        input  out_byte, en,
        output tx, busy, fifo_count, overflow
    );
endinterface

// File: rtl/cpu_out_uart_tx.sv
// Logs every change of the CPU output byte as an 8N1 UART frame.
// Changes are queued in a small FIFO; frames go out back to back.
module cpu_out_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    cpu_out_uart_tx_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    DEPTH5   = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    r_in_q;
    logic [7:0]    r_prev;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [4:0]    r_count;
    logic          r_overflow;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_tx_nxt;
    logic          w_pop;

    logic w_change;
    logic w_push;
    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_bit_end;

    assign w_change  = (r_in_q != r_prev);
    assign w_push    = w_change && bus.en;
    assign w_full    = (r_count == DEPTH5);
    assign w_empty   = (r_count == 5'd0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_accept  = w_push && (!w_full || w_pop);
    assign w_bit_end = (r_cnt == LAST_CNT);

    // Input sync, change tracking and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_q     <= 8'h00;
            r_prev     <= 8'h00;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
        end else begin
            r_in_q <= bus.out_byte;
            if (w_change)
                r_prev <= r_in_q;
            if (w_accept)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            if (w_accept && !w_pop)
                r_count <= r_count + 5'd1;
            else if (!w_accept && w_pop)
                r_count <= r_count - 5'd1;
            if (w_push && !w_accept)
                r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem[r_wr] <= r_in_q;
    end

    // Transmitter state and the registered serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // Next-state logic; tx is derived from the next state so it is
    // registered yet aligned with the state it belongs to.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd];
                    w_cnt_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7)
                        w_state_nxt = STOP;
                    else
                        w_idx_nxt = r_idx + 3'd1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd];
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        unique case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != IDLE);
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Directed bench for cpu_out_uart_tx: latency, framing, FIFO
// overflow, enable gating and asynchronous reset behaviour.
module tb_cpu_out_uart_tx;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    cpu_out_uart_tx_if u_if();

    cpu_out_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Wait for a start bit (bounded), then sample mid-bit.
    // Returns positioned two cycles into the stop bit.
    task automatic recv_frame(input int limit, output logic [7:0] d,
                              output bit got, output bit fr_ok,
                              output int gap);
        logic st;
        logic sp;
        got   = 1'b0;
        fr_ok = 1'b0;
        gap   = 0;
        d     = 8'h00;
        for (int w = 1; w <= limit; w++) begin
            @(posedge clk); #1;
            if (u_if.tx === 1'b0) begin
                gap = w;
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            repeat (2) @(posedge clk);
            #1 st = u_if.tx;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(posedge clk);
                #1 d[i] = u_if.tx;
            end
            repeat (4) @(posedge clk);
            #1 sp = u_if.tx;
            fr_ok = (st === 1'b0) && (sp === 1'b1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        u_if.out_byte = 8'h00;
        u_if.en = 1'b1;
        #3 rst = 1'b1;
        #1;
        n_total++;
        if ({u_if.tx, u_if.busy, u_if.fifo_count, u_if.overflow} !== 8'b1000_0000)
            $display("FAIL reset_async: tx/busy/cnt/ovf=%b/%b/%0d/%b, required 1/0/0/0",
                     u_if.tx, u_if.busy, u_if.fifo_count, u_if.overflow);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({u_if.tx, u_if.busy, u_if.fifo_count, u_if.overflow} !== 8'b1000_0000)
            $display("FAIL reset_held: tx/busy/cnt/ovf=%b/%b/%0d/%b, required 1/0/0/0",
                     u_if.tx, u_if.busy, u_if.fifo_count, u_if.overflow);
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (u_if.tx !== 1'b1 || u_if.busy !== 1'b0)
            $display("FAIL idle_after_reset: tx=%b busy=%b, required 1 0",
                     u_if.tx, u_if.busy);
        else n_pass++;
    endtask

    task automatic test_single_change;
        logic [9:0] bits;
        int bad;
        bits = {1'b1, 8'hA5, 1'b0};
        u_if.out_byte = 8'hA5;
        @(posedge clk); #1;
        n_total++;
        if (u_if.tx !== 1'b1 || u_if.fifo_count !== 5'd0)
            $display("FAIL latency_k: tx=%b cnt=%0d, required 1 0",
                     u_if.tx, u_if.fifo_count);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (u_if.tx !== 1'b1 || u_if.fifo_count !== 5'd1 || u_if.busy !== 1'b0)
            $display("FAIL latency_k1: tx=%b cnt=%0d busy=%b, required 1 1 0",
                     u_if.tx, u_if.fifo_count, u_if.busy);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (u_if.tx !== 1'b0 || u_if.fifo_count !== 5'd0)
            $display("FAIL latency_k2: tx=%b cnt=%0d, required 0 0",
                     u_if.tx, u_if.fifo_count);
        else n_pass++;
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                if (b != 0 || c != 0) begin
                    @(posedge clk); #1;
                end
                if (u_if.tx !== bits[b] || u_if.busy !== 1'b1)
                    bad++;
            end
            n_total++;
            if (bad != 0)
                $display("FAIL a5_bit%0d: %0d bad cycles, required tx=%b busy=1 for 4 cycles",
                         b, bad, bits[b]);
            else n_pass++;
        end
        @(posedge clk); #1;
        n_total++;
        if (u_if.busy !== 1'b0 || u_if.tx !== 1'b1)
            $display("FAIL a5_end: busy=%b tx=%b, required 0 1",
                     u_if.busy, u_if.tx);
        else n_pass++;
    endtask

    task automatic test_static;
        int bad;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (u_if.tx !== 1'b1 || u_if.fifo_count !== 5'd0 || u_if.busy !== 1'b0)
                bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL static_hold: %0d active cycles, required 0", bad);
        else n_pass++;
    endtask

    task automatic test_burst;
        logic [7:0] d [5];
        bit got [5];
        bit fr [5];
        int gap [5];
        int peak;
        logic [7:0] dd;
        bit g;
        bit f;
        int gp;
        peak = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    u_if.out_byte = 8'(i);
                    @(posedge clk); #1;
                    if (int'(u_if.fifo_count) > peak)
                        peak = int'(u_if.fifo_count);
                end
                repeat (6) begin
                    @(posedge clk); #1;
                    if (int'(u_if.fifo_count) > peak)
                        peak = int'(u_if.fifo_count);
                end
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    recv_frame(20, dd, g, f, gp);
                    d[j] = dd;
                    got[j] = g;
                    fr[j] = f;
                    gap[j] = gp;
                end
            end
        join
        n_total++;
        if (peak != 4)
            $display("FAIL burst_peak: fifo_count peak=%0d, required 4", peak);
        else n_pass++;
        for (int j = 0; j < 5; j++) begin
            n_total++;
            if (!got[j] || !fr[j] || d[j] !== 8'(j + 1))
                $display("FAIL burst_frame%0d: got=%0d framed=%0d data=%h, required 1 1 %h",
                         j, got[j], fr[j], d[j], 8'(j + 1));
            else n_pass++;
        end
        for (int j = 1; j < 5; j++) begin
            n_total++;
            if (gap[j] != 2)
                $display("FAIL burst_gap%0d: start %0d cycles after stop mid, required 2",
                         j, gap[j]);
            else n_pass++;
        end
        n_total++;
        if (u_if.overflow !== 1'b1 || u_if.fifo_count !== 5'd0)
            $display("FAIL burst_overflow: ovf=%b cnt=%0d, required 1 0",
                     u_if.overflow, u_if.fifo_count);
        else n_pass++;
        recv_frame(60, dd, g, f, gp);
        n_total++;
        if (g)
            $display("FAIL burst_no_sixth: extra frame data=%h, required none", dd);
        else n_pass++;
    endtask

    task automatic test_enable_gating;
        logic [7:0] dd;
        bit g;
        bit f;
        int gp;
        u_if.en = 1'b0;
        u_if.out_byte = 8'h3C;
        repeat (4) @(posedge clk);
        #1 u_if.en = 1'b1;
        recv_frame(60, dd, g, f, gp);
        n_total++;
        if (g || u_if.fifo_count !== 5'd0)
            $display("FAIL gate_no_replay: frame=%0d data=%h cnt=%0d, required no frame",
                     g, dd, u_if.fifo_count);
        else n_pass++;
        u_if.out_byte = 8'h3D;
        recv_frame(20, dd, g, f, gp);
        n_total++;
        if (!g || !f || dd !== 8'h3D)
            $display("FAIL gate_3d: got=%0d framed=%0d data=%h, required 1 1 3d",
                     g, f, dd);
        else n_pass++;
        recv_frame(60, dd, g, f, gp);
        n_total++;
        if (g)
            $display("FAIL gate_single: extra frame data=%h, required none", dd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] dd;
        bit g;
        bit f;
        int gp;
        u_if.out_byte = 8'h77;
        repeat (14) @(posedge clk);
        #1;
        n_total++;
        if (u_if.busy !== 1'b1 || u_if.overflow !== 1'b1)
            $display("FAIL midframe_pre: busy=%b ovf=%b, required 1 1",
                     u_if.busy, u_if.overflow);
        else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_total++;
        if ({u_if.tx, u_if.busy, u_if.fifo_count, u_if.overflow} !== 8'b1000_0000)
            $display("FAIL midframe_rst: tx/busy/cnt/ovf=%b/%b/%0d/%b, required 1/0/0/0",
                     u_if.tx, u_if.busy, u_if.fifo_count, u_if.overflow);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        recv_frame(20, dd, g, f, gp);
        n_total++;
        if (!g || !f || dd !== 8'h77)
            $display("FAIL midframe_77: got=%0d framed=%0d data=%h, required 1 1 77",
                     g, f, dd);
        else n_pass++;
        recv_frame(60, dd, g, f, gp);
        n_total++;
        if (g)
            $display("FAIL midframe_single: extra frame data=%h, required none", dd);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single_change();
        test_static();
        test_burst();
        test_enable_gating();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu_out_uart_tx.md
Name: cpu_out_uart_tx

Overview:
Downstream stage for the accumulator CPU. It watches the CPU's 8-bit output bus and detects each change of value. Each new value is queued in a small FIFO and serialized as an 8N1 UART frame on a single pin, so a program's output trace can be logged off-chip. It sits between the CPU's output byte and a top-level output pin. It needs no handshake from the CPU.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit (≥2); frame = 10*CLKS_PER_BIT cycles
FIFO_DEPTH, 4, byte entries in the queue; power of 2, range 2..16

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset; clears all state immediately
out_byte  input  8  CPU output bus (uo_out), sampled every cycle
en  input  1  capture enable; 0 = track the value without queuing
tx  output  1  UART serial data; idle high
busy  output  1  1 while a frame is in progress (state != IDLE)
fifo_count  output  5  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky flag: a change was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high) forces: tx=1, busy=0, fifo_count=0, overflow=0, state=IDLE, in_q=0x00, prev=0x00, FIFO pointers=0. Reset mid-frame aborts the frame at once with tx=1 and no partial completion.
- Input stage: in_q <= out_byte every cycle, a single synchronizing register.
- Change detect (registered): if in_q != prev, then prev <= in_q.
  - If en=1 as well, push in_q into the FIFO.
  - If en=0, prev updates but nothing is pushed, so enabling never replays stale changes.
- Full FIFO: a push is dropped and overflow <= 1. overflow stays set until rst. prev still updates.
- Simultaneous push and pop when full: the pop frees a slot, the push is accepted, and fifo_count is unchanged.
- TX FSM states: IDLE, START, DATA, STOP. Each bit is held for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter and a 3-bit index.
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0.
  - DATA: 8 bits, LSB first.
  - STOP: tx=1.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: out_byte is sampled at edge k. in_q updates at k, the push is at k+1, the pop/START is at k+2. tx goes low after edge k+2 when the FIFO was empty and the FSM was idle.
- A held out_byte produces exactly one frame. A value that returns to an earlier value produces a new frame each time it changes.
- fifo_count and overflow are registered outputs. tx is driven from a register (glitch-free).

Test Plan:
1. Reset: assert rst for 2 cycles -> tx=1, busy=0, fifo_count=0, overflow=0; assert rst asynchronously between edges -> outputs clear without waiting for a clock edge.
2. Single change: out_byte 0x00->0xA5 at edge k -> tx low from edge k+2 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; busy=1 for 40 cycles.
3. Static input: hold out_byte=0xA5 for 300 cycles after step 2 -> no further frame; tx stays 1 and fifo_count stays 0.
4. Burst (en=1): out_byte=0x01..0x06 on consecutive cycles -> fifo_count peaks at 4, 0x06 is dropped, overflow=1; frames 01,02,03,04,05 are sent back to back (200 cycles, no idle between frames).
5. Enable gating: with en=0 change to 0x3C, then set en=1 -> no frame; then change to 0x3D -> exactly one frame carrying 0x3D.
6. Reset mid-frame: assert rst during DATA with out_byte=0x77 held -> tx=1 immediately, overflow cleared; after release, exactly one complete frame of 0x77.
